// File: rtl/posit_sgnj_arbiter.sv
// Round-robin arbiter in front of one posit sign-injection datapath (SGNJ/SGNJN/SGNJX)
// with a single backpressured output register carrying the tag and source index.
module posit_sgnj_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*WIDTH-1:0]   req_a_i,
  input  logic [N_REQ*WIDTH-1:0]   req_b_i,
  input  logic [N_REQ*2-1:0]       req_op_i,
  input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_data_o,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic [IDX_W-1:0]         res_src_o,
  output logic                     busy_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [WIDTH-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] src_q;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [1:0]       op_sel;
  logic [TAG_W-1:0] tag_sel;
  logic             sign_bit;
  logic [WIDTH-1:0] result;

  // (base + off) modulo N_REQ; off never exceeds N_REQ, so one subtraction suffices.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!found && req_valid_i[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        grant_idx    = cand;
      end
    end
  end

  assign can_accept  = (state_q == ST_EMPTY) || res_ready_i;
  assign accept      = found && can_accept && !flush_i && !rst_i;
  assign req_ready_o = accept ? grant : '0;

  assign a_sel   = req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel   = req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign op_sel  = req_op_i[int'(grant_idx)*2 +: 2];
  assign tag_sel = req_tag_i[int'(grant_idx)*TAG_W +: TAG_W];

  // Op 11 is not a defined encoding and falls through to plain SGNJ.
  always_comb begin
    sign_bit = b_sel[WIDTH-1];
    case (op_sel)
      2'b01:   sign_bit = ~b_sel[WIDTH-1];
      2'b10:   sign_bit = a_sel[WIDTH-1] ^ b_sel[WIDTH-1];
      default: sign_bit = b_sel[WIDTH-1];
    endcase
  end

  assign result = {sign_bit, a_sel[WIDTH-2:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      src_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
    end else if (accept) begin
      state_q <= ST_FULL;
      ptr_q   <= wrap_add(grant_idx, 1);
      data_q  <= result;
      tag_q   <= tag_sel;
      src_q   <= grant_idx;
    end else if (state_q == ST_FULL && res_ready_i) begin
      state_q <= ST_EMPTY;
    end
  end

  assign res_valid_o = (state_q == ST_FULL);
  assign busy_o      = (state_q == ST_FULL);
  assign res_data_o  = data_q;
  assign res_tag_o   = tag_q;
  assign res_src_o   = src_q;

endmodule

// File: doc/posit_sgnj_arbiter.md
Name: posit_sgnj_arbiter

Overview:
Round-robin arbiter and sequencer that shares one posit sign-injection datapath (SGNJ/SGNJN/SGNJX) between N_REQ requesters, such as issue lanes or a load-convert path, inside the posit FPU. It accepts one operation per cycle through valid/ready handshakes and computes the result in its own instance of the sign-inject logic. The result is held in a single output register with backpressure and returns the requester tag and source index.

Parameters:
WIDTH, 32, posit width in bits
N_REQ, 2, number of requesters (2..8)
TAG_W, 4, width of the per-request tag carried to the output
IDX_W, $clog2(N_REQ) (min 1), derived width of the source index

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  discard the held result and restart arbitration
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
req_a_i  in  N_REQ*WIDTH  operand A per requester (source of magnitude bits)
req_b_i  in  N_REQ*WIDTH  operand B per requester (source of sign)
req_op_i  in  N_REQ*2  operation per requester: 00 SGNJ, 01 SGNJN, 10 SGNJX, 11 treated as SGNJ
req_tag_i  in  N_REQ*TAG_W  per-request tag
res_valid_o  out  1  result valid
res_ready_i  in  1  downstream accept
res_data_o  out  WIDTH  result posit
res_tag_o  out  TAG_W  tag of the producing request
res_src_o  out  IDX_W  index of the producing requester
busy_o  out  1  high while the output register holds an unaccepted result

Behaviour:
- Reset (rst_i=1 at a clock edge): res_valid_o=0, res_data_o=0, res_tag_o=0, res_src_o=0, busy_o=0, round-robin pointer=0. req_ready_o is all zero during the reset cycle.
- Output stage has two states. EMPTY: res_valid_o=0. FULL: res_valid_o=1. busy_o equals FULL.
- can_accept = EMPTY, or FULL with res_ready_i=1 (pass-through refill, so throughput is 1 per cycle).
- Grant: starting at pointer p, pick the first index i in order p, p+1, ..., wrapping modulo N_REQ, with req_valid_i[i]=1. req_ready_o[i] = grant[i] & can_accept & ~flush_i & ~rst_i.
- Accept happens when req_valid_i[i] & req_ready_o[i]. On the next edge:
  - res_data_o = {s, a[WIDTH-2:0]}, where s = b_msb for op 00 and 11, ~b_msb for op 01, and a_msb ^ b_msb for op 10.
  - res_tag_o and res_src_o are loaded, and the stage is FULL.
  - Pointer becomes (i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Latency: a result is visible exactly 1 cycle after accept.
- FULL with res_ready_i=1 and no accept: the stage goes EMPTY next cycle.
- FULL with res_ready_i=0: the stage holds. res_data_o, res_tag_o and res_src_o stay stable, and req_ready_o is all zero.
- No valid requests: no grant, and the pointer is unchanged.
- The grant decision may depend on req_valid_i combinationally. req_ready_o must not depend on res_data_o.
- A requester must hold valid and operands stable until accepted. A requester is guaranteed service within N_REQ accepts (starvation-free).
- flush_i=1:
  - No accept occurs that cycle.
  - Next edge: stage EMPTY, pointer unchanged.
  - flush has priority over res_ready_i. A result being handed off in the same cycle still counts as delivered downstream if res_ready_i=1, but is dropped internally either way.
- Reset mid-operation: the held result is discarded, there is no output pulse, and the pointer returns to 0.
- X-free outputs are required after the first reset.

Test Plan:
- Single request: N_REQ=2. Req0 with a=0x40000000, b=0x80000000, op=00, tag=3, res_ready=1. Expect accept in cycle 0, then res_valid=1 in cycle 1 with data=0xC0000000, tag=3, src=0.
- Op coverage on req1, a=0xC0001234, b=0x00000000. op 01 gives 0xC0001234. op 10 gives 0xC0001234. op 00 gives 0x40001234. op 11 gives 0x40001234.
- Fairness: both requesters valid continuously, res_ready=1. Grants alternate 0,1,0,1 with one result per cycle, and res_src_o follows the same sequence delayed by 1 cycle.
- Backpressure: res_ready=0 for 5 cycles while FULL. req_ready_o stays 0 and the output stays stable. When res_ready rises, the held result is handed off and a new request is accepted in the same cycle.
- Flush: FULL with req0 valid, assert flush_i for 1 cycle. No accept that cycle, res_valid=0 next cycle, then req0 is accepted the following cycle.
- Reset mid-stream: assert rst_i while FULL. Next cycle all outputs are 0 and the pointer is 0 (req0 wins when both requesters are valid).
